// File: rtl/tag_array_2way.sv
// Two-way set-associative tag store: tag/valid/dirty per way, one LRU bit per set,
// single-cycle lookup/fill/invalidate with registered response and a per-set flush sweep.
module tag_array_2way #(
    parameter int TAG_W   = 6,
    parameter int INDEX_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic               resp_way,
    output logic               resp_dirty,
    output logic [TAG_W-1:0]   resp_victim_tag,
    input  logic               flush_start,
    output logic               flush_busy,
    output logic               flush_done
);
    // state    | meaning
    // ST_IDLE  | accepting requests, flush_start launches a sweep
    // ST_FLUSH | clearing one set per cycle, requests stalled

    localparam int SETS = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [1:0][TAG_W-1:0] tag_q   [SETS];
    logic [1:0]            valid_q [SETS];
    logic [1:0]            dirty_q [SETS];
    logic                  lru_q   [SETS];
    logic [INDEX_W-1:0]    flush_idx;

    logic [1:0][TAG_W-1:0] set_tag;
    logic [1:0]            set_valid;
    logic [1:0]            set_dirty;
    logic                  set_lru;
    logic                  accept;
    logic                  flush_last;
    logic                  hit0;
    logic                  hit1;
    logic                  hit;
    logic                  victim_way;
    logic                  sel_way;

    assign req_ready  = (state == ST_IDLE) & ~flush_start;
    assign flush_busy = (state == ST_FLUSH);
    assign accept     = req_valid & req_ready;
    assign flush_last = (flush_idx == LAST_SET);

    assign set_tag   = tag_q[req_index];
    assign set_valid = valid_q[req_index];
    assign set_dirty = dirty_q[req_index];
    assign set_lru   = lru_q[req_index];

    assign hit0 = set_valid[0] & (set_tag[0] == req_tag);
    assign hit1 = set_valid[1] & (set_tag[1] == req_tag);
    assign hit  = hit0 | hit1;

    // Empty ways are always preferred over evicting a live entry.
    assign victim_way = ~set_valid[0] ? 1'b0 : (~set_valid[1] ? 1'b1 : set_lru);
    assign sel_way    = hit ? hit1 : victim_way;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (flush_start) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            flush_idx  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_idx  <= (state == ST_FLUSH) ? flush_idx + INDEX_W'(1) : '0;
            flush_done <= (state == ST_FLUSH) & flush_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]   <= '0;
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= 1'b0;
            end
        end else if (state == ST_FLUSH) begin
            valid_q[flush_idx] <= '0;
            dirty_q[flush_idx] <= '0;
            lru_q[flush_idx]   <= 1'b0;
        end else if (accept) begin
            case (req_op)
                OP_READ: begin
                    if (hit) lru_q[req_index] <= ~hit1;
                end
                OP_WRITE: begin
                    if (hit) begin
                        lru_q[req_index]         <= ~hit1;
                        dirty_q[req_index][hit1] <= 1'b1;
                    end
                end
                OP_FILL: begin
                    // A fill that already hits only refreshes LRU, so no duplicate tag is created.
                    if (hit) begin
                        lru_q[req_index] <= ~hit1;
                    end else begin
                        tag_q[req_index][victim_way]   <= req_tag;
                        valid_q[req_index][victim_way] <= 1'b1;
                        dirty_q[req_index][victim_way] <= 1'b0;
                        lru_q[req_index]               <= ~victim_way;
                    end
                end
                OP_INVAL: begin
                    if (hit) begin
                        valid_q[req_index][hit1] <= 1'b0;
                        dirty_q[req_index][hit1] <= 1'b0;
                        lru_q[req_index]         <= hit1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid      <= 1'b0;
            resp_hit        <= 1'b0;
            resp_way        <= 1'b0;
            resp_dirty      <= 1'b0;
            resp_victim_tag <= '0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_hit        <= hit;
                resp_way        <= sel_way;
                resp_dirty      <= set_dirty[sel_way] & set_valid[sel_way];
                resp_victim_tag <= set_tag[sel_way];
            end
        end
    end

endmodule

// File: tb/tb_tag_array_2way.sv
// Bench for tag_array_2way: directed scenarios with literal expectations, then random
// traffic checked every cycle against a way-recency model of the tag store.
module tb_tag_array_2way;
    localparam int TAG_W   = 6;
    localparam int INDEX_W = 2;
    localparam int SETS    = 4;

    logic               clk;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               resp_valid;
    logic               resp_hit;
    logic               resp_way;
    logic               resp_dirty;
    logic [TAG_W-1:0]   resp_victim_tag;
    logic               flush_start;
    logic               flush_busy;
    logic               flush_done;

    int n_vec = 0;
    int n_err = 0;

    tag_array_2way #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_dirty      (resp_dirty),
        .resp_victim_tag (resp_victim_tag),
        .flush_start     (flush_start),
        .flush_busy      (flush_busy),
        .flush_done      (flush_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-way contents plus the most recently used way of each set.
    int mvalid [SETS][2];
    int mdirty [SETS][2];
    int mtag   [SETS][2];
    int mrecent[SETS];
    int flush_left = 0;
    int flush_pos  = 0;
    int exp_valid = 0, exp_done = 0, exp_hit = 0, exp_way = 0, exp_dirty = 0;
    int exp_vtag = 0, exp_known = 0;

    task automatic model_clear_set(input int s);
        mvalid[s][0] = 0; mvalid[s][1] = 0;
        mdirty[s][0] = 0; mdirty[s][1] = 0;
        mrecent[s]   = 1;
    endtask

    task automatic model_apply(input int op, input int s, input int tag);
        int h;
        int sel;
        h = -1;
        for (int w = 0; w < 2; w++)
            if (mvalid[s][w] != 0 && mtag[s][w] == tag) h = w;
        if (h >= 0)             sel = h;
        else if (mvalid[s][0] == 0) sel = 0;
        else if (mvalid[s][1] == 0) sel = 1;
        else                    sel = 1 - mrecent[s];
        exp_valid = 1;
        exp_hit   = (h >= 0) ? 1 : 0;
        exp_way   = sel;
        exp_dirty = (mvalid[s][sel] != 0 && mdirty[s][sel] != 0) ? 1 : 0;
        exp_vtag  = mtag[s][sel];
        exp_known = mvalid[s][sel];
        case (op)
            0: if (h >= 0) mrecent[s] = h;
            1: if (h >= 0) begin mrecent[s] = h; mdirty[s][h] = 1; end
            2: begin
                if (h >= 0) mrecent[s] = h;
                else begin
                    mtag[s][sel] = tag; mvalid[s][sel] = 1; mdirty[s][sel] = 0; mrecent[s] = sel;
                end
            end
            default: if (h >= 0) begin mvalid[s][h] = 0; mdirty[s][h] = 0; mrecent[s] = 1 - h; end
        endcase
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) begin
            model_clear_set(s);
            mtag[s][0] = 0; mtag[s][1] = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) model_clear_set(s);
            flush_left = 0; flush_pos = 0; exp_valid = 0; exp_done = 0;
            exp_hit = 0; exp_way = 0; exp_dirty = 0; exp_known = 0;
        end else begin
            exp_valid = 0;
            exp_done  = 0;
            if (flush_left > 0) begin
                model_clear_set(flush_pos);
                flush_pos++;
                flush_left--;
                if (flush_left == 0) exp_done = 1;
            end else if (flush_start) begin
                flush_left = SETS;
                flush_pos  = 0;
            end else if (req_valid) begin
                model_apply(int'(req_op), int'(req_index), int'(req_tag));
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'((flush_left == 0 && !flush_start) ? 1 : 0));
        check("flush_busy", 32'(flush_busy), 32'((flush_left > 0) ? 1 : 0));
        check("flush_done", 32'(flush_done), 32'(exp_done));
        check("resp_valid", 32'(resp_valid), 32'(exp_valid));
        if (exp_valid != 0) begin
            check("resp_hit", 32'(resp_hit), 32'(exp_hit));
            check("resp_way", 32'(resp_way), 32'(exp_way));
            check("resp_dirty", 32'(resp_dirty), 32'(exp_dirty));
            if (exp_known != 0) check("resp_victim_tag", 32'(resp_victim_tag), 32'(exp_vtag));
        end
    end

    // Issue one request at the current phase, let it be accepted, check the response literally.
    task automatic do_req(input string nm, input logic [1:0] op, input logic [1:0] idx,
                          input logic [5:0] tag, input logic e_hit, input logic e_way,
                          input logic e_dirty, input logic chk_tag, input logic [5:0] e_tag);
        req_valid = 1'b1; req_op = op; req_index = idx; req_tag = tag;
        @(posedge clk); #2;
        req_valid = 1'b0;
        #1;
        check({nm, ".valid"}, 32'(resp_valid), 32'(1));
        check({nm, ".hit"},   32'(resp_hit),   32'(e_hit));
        check({nm, ".way"},   32'(resp_way),   32'(e_way));
        check({nm, ".dirty"}, 32'(resp_dirty), 32'(e_dirty));
        if (chk_tag) check({nm, ".vtag"}, 32'(resp_victim_tag), 32'(e_tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_index = '0; req_tag = '0;
        flush_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'(1));
        check("resp_valid_after_reset", 32'(resp_valid), 32'(0));

        do_req("rd1_03_cold", 2'b00, 2'd1, 6'h03, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("fill1_03",    2'b10, 2'd1, 6'h03, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("fill1_04",    2'b10, 2'd1, 6'h04, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
        do_req("rd1_03",      2'b00, 2'd1, 6'h03, 1'b1, 1'b0, 1'b0, 1'b1, 6'h03);
        do_req("fill1_05",    2'b10, 2'd1, 6'h05, 1'b0, 1'b1, 1'b0, 1'b1, 6'h04);
        do_req("fill2_10",    2'b10, 2'd2, 6'h10, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("wr2_10",      2'b01, 2'd2, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1, 6'h10);
        do_req("fill2_11",    2'b10, 2'd2, 6'h11, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
        do_req("rd2_11",      2'b00, 2'd2, 6'h11, 1'b1, 1'b1, 1'b0, 1'b1, 6'h11);
        do_req("fill2_12",    2'b10, 2'd2, 6'h12, 1'b0, 1'b0, 1'b1, 1'b1, 6'h10);
        do_req("refill2_12",  2'b10, 2'd2, 6'h12, 1'b1, 1'b0, 1'b0, 1'b1, 6'h12);
        do_req("inv1_03",     2'b11, 2'd1, 6'h03, 1'b1, 1'b0, 1'b0, 1'b1, 6'h03);
        do_req("rd1_03_gone", 2'b00, 2'd1, 6'h03, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("inv1_3f",     2'b11, 2'd1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("rd1_05",      2'b00, 2'd1, 6'h05, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05);

        // Flush collides with a pending request: flush wins, the request is held.
        req_valid = 1'b1; req_op = 2'b00; req_index = 2'd2; req_tag = 6'h12; flush_start = 1'b1;
        #1;
        check("ready_blocked_by_flush", 32'(req_ready), 32'(0));
        @(posedge clk); #2;
        flush_start = 1'b0;
        #1;
        n = 0;
        while (flush_busy && n < 20) begin
            n++;
            @(posedge clk); #3;
        end
        check("flush_len", 32'(n), 32'(4));
        check("flush_done_pulse", 32'(flush_done), 32'(1));
        check("ready_after_flush", 32'(req_ready), 32'(1));
        @(posedge clk); #2;
        req_valid = 1'b0;
        #1;
        check("held_req.valid", 32'(resp_valid), 32'(1));
        check("held_req.hit", 32'(resp_hit), 32'(0));
        check("flush_done_one_cycle", 32'(flush_done), 32'(0));
        do_req("post_flush_rd1_05", 2'b00, 2'd1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        do_req("post_flush_rd2_11", 2'b00, 2'd2, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);

        // Reset lands in the second flush cycle.
        flush_start = 1'b1;
        @(posedge clk); #2;
        flush_start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(flush_busy), 32'(0));
        check("abort_resp_valid", 32'(resp_valid), 32'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 32'(req_ready), 32'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            check("abort_no_done", 32'(flush_done), 32'(0));
        end

        // Random traffic over a small tag pool so hits, evictions and dirty victims are common.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            req_valid   = ($urandom_range(0, 3) != 0);
            req_op      = 2'($urandom_range(0, 3));
            req_index   = 2'($urandom_range(0, 3));
            req_tag     = 6'($urandom_range(0, 4));
            flush_start = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #2;
        req_valid = 1'b0; flush_start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
